// File: rtl/rr_arb_83_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter: state encoding,
// display constants and the rotating-priority pick.
package arb83_pkg;

  localparam int N  = 8;
  localparam int IW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Rotate right so bit 0 is the requester at ptr, take the lowest set bit,
  // then rotate the index back; the 3-bit add wraps mod 8 for free.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0]  req,
                                            input logic [IW-1:0] ptr);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    return off + ptr;
  endfunction

endpackage

// File: rtl/rr_arb_83_if.sv
// Request/grant bundle between the requesting agents and the arbiter.
interface rr_arb_83_if;
  import arb83_pkg::*;

  logic          en;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          tout;
  logic [6:0]    seg;

  modport master (output en, req,
                  input  gnt, gnt_idx, gnt_valid, tout, seg);

  modport slave  (input  en, req,
                  output gnt, gnt_idx, gnt_valid, tout, seg);

endinterface

// File: rtl/rr_arb_83_bcd7seg.sv
// 3-bit value to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module bcd7seg (
  input  logic [2:0] val,
  output logic [6:0] seg
);

  always_comb begin
    unique case (val)
      3'd0: seg = 7'h40;
      3'd1: seg = 7'h79;
      3'd2: seg = 7'h24;
      3'd3: seg = 7'h30;
      3'd4: seg = 7'h19;
      3'd5: seg = 7'h12;
      3'd6: seg = 7'h02;
      3'd7: seg = 7'h78;
    endcase
  end

endmodule

// File: rtl/rr_arb_83.sv
// 8-requester round-robin arbiter with registered one-hot grant, hold-time
// limit with forced release, one-cycle handover bubble and owner display.
module rr_arb_83
  import arb83_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic        clk,
  input  logic        rst,
  rr_arb_83_if.slave  bus
);

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          valid_q, valid_d;
  logic          tout_q, tout_d;

  logic [IW-1:0] winner;
  logic          arb_go;
  logic          owner_req;
  logic          expired;
  logic [6:0]    seg_raw;

  assign winner    = rr_pick(bus.req, ptr_q);
  assign arb_go    = bus.en && (|bus.req);
  assign owner_req = bus.req[idx_q];
  assign expired   = (cnt_q == CW'(MAX_HOLD - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
    end
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_go) state_d = GRANT;
      GRANT: begin
        if (!bus.en)                  state_d = IDLE;
        else if (!owner_req || expired) state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs; a plain request drop outranks expiry.
  always_comb begin
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    tout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_go) begin
          gnt_d         = '0;
          gnt_d[winner] = 1'b1;
          idx_d         = winner;
          valid_d       = 1'b1;
          cnt_d         = '0;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + CW'(1);
        if (!bus.en) begin
          gnt_d   = '0;
          valid_d = 1'b0;
        end else if (!owner_req || expired) begin
          gnt_d   = '0;
          valid_d = 1'b0;
          ptr_d   = idx_q + IW'(1);
          tout_d  = owner_req;
        end
      end
      default: begin
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  bcd7seg u_seg (
    .val (idx_q),
    .seg (seg_raw)
  );

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.tout      = tout_q;
  assign bus.seg       = valid_q ? seg_raw : SEG_BLANK;

endmodule

// File: tb/tb_rr_arb_83.sv
// Directed and randomized bench for rr_arb_83 against a per-cycle behavioural
// model of owner, tenure length and rotation pointer.
module tb_rr_arb_83;

  localparam int MAX_HOLD = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rr_arb_83_if bus ();

  rr_arb_83 #(.MAX_HOLD(MAX_HOLD), .CW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit m_valid;
  int m_owner;
  int m_last;
  int m_held;
  int m_ptr;
  bit m_bubble;
  bit m_tout;
  int run_len;

  logic [6:0] seg_tab [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_owner  = 0;
    m_last   = 0;
    m_held   = 0;
    m_ptr    = 0;
    m_bubble = 1'b0;
    m_tout   = 1'b0;
  endtask

  // One clock edge of the arbiter's rules, using the inputs present at that edge.
  task automatic model_step();
    m_tout = 1'b0;
    if (m_valid) begin
      if (!bus.en) begin
        m_valid = 1'b0;
      end else if (!bus.req[m_owner]) begin
        m_valid  = 1'b0;
        m_ptr    = (m_owner + 1) % 8;
        m_bubble = 1'b1;
      end else if (m_held == MAX_HOLD) begin
        m_valid  = 1'b0;
        m_ptr    = (m_owner + 1) % 8;
        m_bubble = 1'b1;
        m_tout   = 1'b1;
      end else begin
        m_held++;
      end
    end else if (m_bubble) begin
      m_bubble = 1'b0;
    end else if (bus.en && bus.req != 0) begin
      for (int k = 0; k < 8; k++) begin
        if (!m_valid && bus.req[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          m_last  = m_owner;
          m_held  = 1;
          m_valid = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] exp_gnt;
    exp_gnt = m_valid ? (32'd1 << m_owner) : 32'd0;
    check("gnt",       bus.gnt,       exp_gnt);
    check("gnt_idx",   bus.gnt_idx,   m_last);
    check("gnt_valid", bus.gnt_valid, m_valid);
    check("tout",      bus.tout,      m_tout);
    check("seg",       bus.seg,       m_valid ? seg_tab[m_owner] : 7'h7F);
    check("onehot0",   $onehot0(bus.gnt), 1);
    check("valid_or",  bus.gnt_valid, |bus.gnt);
  endtask

  // Advance one clock: model at the edge, compare on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    check_outputs();
    if (bus.gnt_valid) begin
      run_len++;
    end else begin
      if (run_len > 0 && bus.tout) check("tenure_len", run_len, MAX_HOLD);
      run_len = 0;
    end
  endtask

  task automatic wait_owner(input int idx, input int budget, input string tag);
    int n;
    n = 0;
    while (!(bus.gnt_valid && bus.gnt_idx == idx) && n < budget) begin
      cycle();
      n++;
    end
    check(tag, {bus.gnt_valid, 3'(bus.gnt_idx)}, {1'b1, 3'(idx)});
  endtask

  initial begin
    int n;
    bus.en  = 1'b0;
    bus.req = '0;
    run_len = 0;
    model_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    check_outputs();
    check("reset_seg", bus.seg, 7'h7F);
    cycle();
    rst = 1'b0;

    // 1: two requesters, owner drops, bubble then handover to agent 2
    bus.en  = 1'b1;
    bus.req = 8'b0000_0101;
    cycle();
    check("t1_first_gnt", bus.gnt, 8'h01);
    repeat (3) cycle();
    bus.req = 8'b0000_0100;
    cycle();
    check("t1_gap_gnt", bus.gnt, 8'h00);
    cycle();
    check("t1_arb_gnt", bus.gnt, 8'h00);
    cycle();
    check("t1_gnt2", bus.gnt, 8'h04);
    check("t1_idx2", bus.gnt_idx, 2);
    check("t1_seg2", bus.seg, 7'h24);

    // 2: everyone requesting, tenures expire and rotate
    bus.req = 8'hFF;
    repeat (8 * (MAX_HOLD + 2) + 4) cycle();

    // 3: sole requester 7 is re-granted after each forced release
    bus.req = 8'h80;
    repeat (3 * (MAX_HOLD + 2)) cycle();

    // 4: abort mid-tenure of agent 3, pointer must not move
    bus.req = 8'h08;
    wait_owner(3, 40, "t4_owner3");
    repeat (3) cycle();
    bus.en = 1'b0;
    cycle();
    check("t4_abort_gnt",  bus.gnt,  8'h00);
    check("t4_abort_tout", bus.tout, 1'b0);
    check("t4_abort_seg",  bus.seg,  7'h7F);
    bus.en  = 1'b1;
    bus.req = 8'h18;
    cycle();
    check("t4_regrant", bus.gnt, 8'h08);

    // 5: owner drops on the very last permitted cycle -> plain release
    n = 0;
    while (!(m_valid && m_held == MAX_HOLD) && n < 40) begin
      cycle();
      n++;
    end
    check("t5_still_owned", bus.gnt_valid, 1'b1);
    bus.req = 8'h00;
    cycle();
    check("t5_no_tout", bus.tout, 1'b0);
    check("t5_gnt0",    bus.gnt,  8'h00);

    // 6: asynchronous reset during a tenure
    bus.req = 8'h20;
    wait_owner(5, 10, "t6_owner5");
    repeat (2) cycle();
    #2 rst = 1'b1;
    #1;
    check("t6_rst_gnt",   bus.gnt,       8'h00);
    check("t6_rst_valid", bus.gnt_valid, 1'b0);
    check("t6_rst_idx",   bus.gnt_idx,   0);
    check("t6_rst_tout",  bus.tout,      1'b0);
    check("t6_rst_seg",   bus.seg,       7'h7F);
    model_reset();
    cycle();
    rst     = 1'b0;
    bus.req = 8'h82;
    cycle();
    check("t6_post_rst_gnt", bus.gnt, 8'h02);

    // 7: randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.en = ($urandom_range(0, 15) != 0);
      case ($urandom_range(0, 4))
        0:       bus.req = 8'($urandom);
        1:       bus.req = 8'h01 << $urandom_range(0, 7);
        2:       bus.req = 8'h00;
        default: bus.req = bus.req;
      endcase
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
